// File: rtl/bitwise_logic_unit.sv
// ---------------------------------------------------------------------------
// bitwise_logic_unit
//
// Two-stage valid/ready pipeline that applies a bitwise operation to two
// WIDTH-bit operands. Stage 1 holds the raw operands and op code, stage 2
// holds the computed result. Each stage moves independently, so with
// out_ready held high the unit sustains one beat per cycle.
//
// Optional feature macro: BLU_FLAGS_EN
//   When defined, the unit also provides the zero and parity flags. Both
//   flags are registered in stage 2 next to Y.
//
// Parameters
//   WIDTH  operand/result width (1..64)
//   CNT_W  width of the completed-output-handshake counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand beat present
//   in_ready   unit can take a beat this cycle (combinational)
//   A, B       operands
//   op         0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN, 7 PASS
//   out_valid  result beat present (stage 2 valid)
//   out_ready  downstream accepts the result
//   Y          result (registered)
//   count      number of output handshakes, wraps at 2^CNT_W
//   zero       Y == 0           (BLU_FLAGS_EN only)
//   parity     XOR-reduction of Y (BLU_FLAGS_EN only)
// ---------------------------------------------------------------------------
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
`ifdef BLU_FLAGS_EN
    output logic             zero,
    output logic             parity,
`endif
    output logic [CNT_W-1:0] count
);

    // Bitwise operation selected by op_v.
    function automatic logic [WIDTH-1:0] compute_result(
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v,
        input logic [2:0]       op_v
    );
        logic [WIDTH-1:0] res_v;
        case (op_v)
            3'd0:    res_v = a_v & b_v;
            3'd1:    res_v = a_v | b_v;
            3'd2:    res_v = a_v ^ b_v;
            3'd3:    res_v = ~(a_v & b_v);
            3'd4:    res_v = ~(a_v | b_v);
            3'd5:    res_v = ~(a_v ^ b_v);
            3'd6:    res_v = a_v & ~b_v;
            3'd7:    res_v = a_v;
            default: res_v = a_v;
        endcase
        return res_v;
    endfunction

`ifdef BLU_FLAGS_EN
    // Even-parity bit of a result word.
    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction
`endif

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] y_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] result_s;
    logic             s1_load_s;
    logic             s2_load_s;
    logic             out_hs_s;
`ifdef BLU_FLAGS_EN
    logic             zero_r;
    logic             parity_r;
`endif

    // Stage load enables and in_ready; stage 2 frees up in the same cycle
    // it hands its beat downstream, so in_ready can stay high when full.
    always_comb begin
        s2_load_s = s1_valid_r & (~s2_valid_r | out_ready);
        in_ready  = ~s1_valid_r | s2_load_s;
        s1_load_s = in_valid & in_ready;
        out_hs_s  = s2_valid_r & out_ready;
        result_s  = compute_result(s1_a_r, s1_b_r, s1_op_r);
    end

    // Stage 1: operand capture and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 3'd0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= 1'b1;
                s1_a_r     <= A;
                s1_b_r     <= B;
                s1_op_r    <= op;
            end else if (s2_load_s) begin
                s1_valid_r <= 1'b0;
            end
        end
    end

    // Stage 2: result register; holds Y/flags steady while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            y_r        <= {WIDTH{1'b0}};
`ifdef BLU_FLAGS_EN
            zero_r     <= 1'b1;
            parity_r   <= 1'b0;
`endif
        end else begin
            if (s2_load_s) begin
                s2_valid_r <= 1'b1;
                y_r        <= result_s;
`ifdef BLU_FLAGS_EN
                zero_r     <= (result_s == {WIDTH{1'b0}});
                parity_r   <= parity_of(result_s);
`endif
            end else if (out_hs_s) begin
                s2_valid_r <= 1'b0;
            end
        end
    end

    // Completed-output counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = s2_valid_r;
    assign Y         = y_r;
    assign count     = count_r;
`ifdef BLU_FLAGS_EN
    assign zero      = zero_r;
    assign parity    = parity_r;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// ---------------------------------------------------------------------------
// tb_bitwise_logic_unit
//
// Self-checking bench for bitwise_logic_unit (WIDTH=8, CNT_W=4). A queue of
// in-flight expected results models the pipeline: the oldest entry becomes
// visible one edge after its acceptance edge, at most two beats are held,
// and a third is taken only when the oldest leaves in the same cycle.
// Flags are checked when BLU_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_bitwise_logic_unit;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [2:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Y;
    logic [CW-1:0] count;
`ifdef BLU_FLAGS_EN
    logic          zero;
    logic          parity;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_log[$];
    int           cnt_m;
    bit           just_acc;

    bitwise_logic_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y        (Y),
`ifdef BLU_FLAGS_EN
        .zero     (zero),
        .parity   (parity),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] o);
        logic [W-1:0] ones = 8'hFF;
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ones - (a & b);
            3'd4:    return ones - (a | b);
            3'd5:    return ones - (a ^ b);
            3'd6:    return a & (ones - b);
            default: return a;
        endcase
    endfunction

    // One clock cycle: drive, check visible state against the model, clock, update.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] o, input logic ordy);
        int   n;
        logic exp_rdy;
        logic exp_ov;
        bit   in_hs;
        bit   out_hs;
        in_valid  = iv;
        A         = a;
        B         = b;
        op        = o;
        out_ready = ordy;
        #1;
        n       = exp_q.size();
        exp_rdy = (n <= 1) || ordy;
        exp_ov  = (n == 2) || (n == 1 && !just_acc);
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
        if (exp_ov) begin
            check("Y", {56'd0, Y}, {56'd0, exp_q[0]});
`ifdef BLU_FLAGS_EN
            check("zero", {63'd0, zero}, {63'd0, (exp_q[0] == 8'h00)});
            check("parity", {63'd0, parity}, {63'd0, ^exp_q[0]});
`endif
        end
        out_hs = exp_ov && ordy;
        in_hs  = iv && exp_rdy;
        @(posedge clk);
        if (out_hs) begin
            out_log.push_back(exp_q.pop_front());
            cnt_m = (cnt_m + 1) % 16;
        end
        if (in_hs) exp_q.push_back(ref_op(a, b, o));
        just_acc = in_hs;
        #1;
        check("count", {60'd0, count}, cnt_m);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 8'($urandom), 8'($urandom), 3'($urandom), ordy);
    endtask

    // Asynchronous reset pulse, checked immediately, released after one edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_count", {60'd0, count}, 64'd0);
        check("rst_Y", {56'd0, Y}, 64'd0);
`ifdef BLU_FLAGS_EN
        check("rst_zero", {63'd0, zero}, 64'd1);
        check("rst_parity", {63'd0, parity}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        out_log.delete();
        cnt_m    = 0;
        just_acc = 1'b0;
    endtask

    logic [W-1:0] seq33[8];

    initial begin
        seq33[0] = 8'h88; seq33[1] = 8'hEE; seq33[2] = 8'h66; seq33[3] = 8'h77;
        seq33[4] = 8'h11; seq33[5] = 8'h99; seq33[6] = 8'h44; seq33[7] = 8'hCC;
        in_valid = 1'b0; A = 8'h00; B = 8'h00; op = 3'd0; out_ready = 1'b1;
        rst = 1'b0; cnt_m = 0; just_acc = 1'b0;
        #3;
        do_reset();

        // Single AND beat: visible after the edge following acceptance.
        step(1'b1, 8'hCC, 8'hAA, 3'd0, 1'b1);
        idle(1'b1);
        check("single_Y", {56'd0, Y}, 64'h88);
        idle(1'b1);
        check("single_count", {60'd0, count}, 64'd1);
        repeat (2) idle(1'b1);

        // All eight ops back-to-back.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'hCC, 8'hAA, 3'(i), 1'b1);
        repeat (3) idle(1'b1);
        check("seq_len", out_log.size(), 64'd8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            check("seq_Y", {56'd0, out_log[i]}, {56'd0, seq33[i]});
        check("seq_count", {60'd0, count}, 64'd8);

        // Stall: three beats offered with out_ready low, then drain.
        do_reset();
        step(1'b1, 8'h0F, 8'h33, 3'd0, 1'b0);
        step(1'b1, 8'h0F, 8'h33, 3'd1, 1'b0);
        step(1'b1, 8'h0F, 8'h33, 3'd2, 1'b0);
        step(1'b1, 8'h0F, 8'h33, 3'd2, 1'b0);
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check("stall_Y_held", {56'd0, Y}, 64'h03);
        step(1'b1, 8'h0F, 8'h33, 3'd2, 1'b1);
        repeat (4) idle(1'b1);
        check("stall_len", out_log.size(), 64'd3);
        if (out_log.size() == 3) begin
            check("stall_r0", {56'd0, out_log[0]}, 64'h03);
            check("stall_r1", {56'd0, out_log[1]}, 64'h3F);
            check("stall_r2", {56'd0, out_log[2]}, 64'h3C);
        end

        // Reset with two beats in flight discards both.
        step(1'b1, 8'h12, 8'h34, 3'd1, 1'b0);
        step(1'b1, 8'h56, 8'h78, 3'd2, 1'b0);
        do_reset();
        repeat (4) idle(1'b1);
        check("post_rst_none", out_log.size(), 64'd0);

        // Counter wrap with CNT_W=4.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
        repeat (2) idle(1'b1);
        check("wrap16", {60'd0, count}, 64'd0);
        step(1'b1, 8'h01, 8'h02, 3'd1, 1'b1);
        repeat (2) idle(1'b1);
        check("wrap17", {60'd0, count}, 64'd1);

`ifdef BLU_FLAGS_EN
        // Flag corner values.
        do_reset();
        step(1'b1, 8'h5A, 8'h5A, 3'd2, 1'b0);
        idle(1'b0);
        check("flag_zero1", {63'd0, zero}, 64'd1);
        check("flag_par0", {63'd0, parity}, 64'd0);
        step(1'b1, 8'h01, 8'h00, 3'd1, 1'b1);
        idle(1'b1);
        check("flag_zero0", {63'd0, zero}, 64'd0);
        check("flag_par1", {63'd0, parity}, 64'd1);
        repeat (2) idle(1'b1);
`endif

        // Random traffic with random backpressure.
        do_reset();
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
                 1'($urandom_range(0, 2) != 0));
        repeat (4) idle(1'b1);
        check("random_drained", exp_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
